// File: rtl/map_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : map_arbiter_if
// Description : Bundles the two lookup request ports, the map ROM address /
//               data path and the shared response bus of map_arbiter.
//               master : the requester side (tracer, overlay, ROM model).
//               slave  : the arbiter side.
// Signals     : req0_valid/col/row/ready  port 0 (tracer) lookup request
//               req1_valid/col/row/ready  port 1 (overlay/debug) request
//               rom_col, rom_row          registered address to map ROM
//               rom_val                   combinational ROM data back
//               resp0_valid, resp1_valid  one-cycle response pulses
//               resp_val                  shared registered lookup result
// Revision    : 1.0  initial release
// ============================================================================
interface map_arbiter_if #(
  parameter int COLBITS = 4,
  parameter int ROWBITS = 4,
  parameter int BITS    = 2
);
  logic               req0_valid;
  logic [COLBITS-1:0] req0_col;
  logic [ROWBITS-1:0] req0_row;
  logic               req0_ready;

  logic               req1_valid;
  logic [COLBITS-1:0] req1_col;
  logic [ROWBITS-1:0] req1_row;
  logic               req1_ready;

  logic [COLBITS-1:0] rom_col;
  logic [ROWBITS-1:0] rom_row;
  logic [BITS-1:0]    rom_val;

  logic               resp0_valid;
  logic               resp1_valid;
  logic [BITS-1:0]    resp_val;

  modport master (
    output req0_valid, req0_col, req0_row,
    input  req0_ready,
    output req1_valid, req1_col, req1_row,
    input  req1_ready,
    input  rom_col, rom_row,
    output rom_val,
    input  resp0_valid, resp1_valid, resp_val
  );

  modport slave (
    input  req0_valid, req0_col, req0_row,
    output req0_ready,
    input  req1_valid, req1_col, req1_row,
    output req1_ready,
    output rom_col, rom_row,
    input  rom_val,
    output resp0_valid, resp1_valid, resp_val
  );
endinterface
`default_nettype wire

// File: rtl/map_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : map_arbiter
// Description : Two-port arbiter in front of a combinational map ROM.
//               Port 0 (tracer) has priority; port 1 is forced a grant once
//               it has been denied MAXWAIT times. Two-stage pipeline:
//               stage 1 registers the ROM address and requester id, stage 2
//               captures the ROM value and pulses the per-port response.
// Ports       : clk      single clock, rising edge
//               reset_n  asynchronous active-low reset
//               bus      map_arbiter_if.slave (requests, ROM, responses)
// Revision    : 1.0  initial release
// ============================================================================
module map_arbiter #(
  parameter int COLBITS = 4,
  parameter int ROWBITS = 4,
  parameter int BITS    = 2,
  parameter int MAXWAIT = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  map_arbiter_if.slave  bus
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAXWAIT);
  localparam logic [3:0] WAIT_SAT   = 4'hF;

  logic               grant0;
  logic               grant1;

  logic [3:0]         wait1_q,     wait1_d;
  logic               s1_valid_q,  s1_valid_d;
  logic               s1_id_q,     s1_id_d;
  logic [COLBITS-1:0] rom_col_q,   rom_col_d;
  logic [ROWBITS-1:0] rom_row_q,   rom_row_d;
  logic [BITS-1:0]    resp_val_q,  resp_val_d;
  logic               resp0_q,     resp0_d;
  logic               resp1_q,     resp1_d;

  // Arbitration. Grants double as readies, so reset_n gates them directly:
  // nothing may be accepted while reset is held, whatever the valids say.
  always_comb begin
    grant1 = reset_n && bus.req1_valid &&
             (!bus.req0_valid || (wait1_q >= WAIT_LIMIT));
    grant0 = reset_n && bus.req0_valid && !grant1;
  end

  always_comb begin
    // Starvation counter for port 1: counts denied cycles while it asks.
    wait1_d = wait1_q;
    if (grant1) begin
      wait1_d = 4'd0;
    end else if (bus.req1_valid && (wait1_q != WAIT_SAT)) begin
      wait1_d = wait1_q + 4'd1;
    end

    // Stage 1: address to ROM plus requester id.
    s1_valid_d = grant0 || grant1;
    s1_id_d    = grant1;
    rom_col_d  = rom_col_q;
    rom_row_d  = rom_row_q;
    if (grant1) begin
      rom_col_d = bus.req1_col;
      rom_row_d = bus.req1_row;
    end else if (grant0) begin
      rom_col_d = bus.req0_col;
      rom_row_d = bus.req0_row;
    end

    // Stage 2: capture the ROM value; resp_val is sticky between pulses.
    resp0_d    = s1_valid_q && !s1_id_q;
    resp1_d    = s1_valid_q &&  s1_id_q;
    resp_val_d = s1_valid_q ? bus.rom_val : resp_val_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait1_q    <= 4'd0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= 1'b0;
      rom_col_q  <= '0;
      rom_row_q  <= '0;
      resp_val_q <= '0;
      resp0_q    <= 1'b0;
      resp1_q    <= 1'b0;
    end else begin
      wait1_q    <= wait1_d;
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      rom_col_q  <= rom_col_d;
      rom_row_q  <= rom_row_d;
      resp_val_q <= resp_val_d;
      resp0_q    <= resp0_d;
      resp1_q    <= resp1_d;
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.rom_col     = rom_col_q;
  assign bus.rom_row     = rom_row_q;
  assign bus.resp_val    = resp_val_q;
  assign bus.resp0_valid = resp0_q;
  assign bus.resp1_valid = resp1_q;

endmodule
`default_nettype wire

// File: tb/tb_map_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_map_arbiter
// Description : Self-checking bench for map_arbiter. A transaction-level
//               model (queue of expected responses with due cycles, a
//               denied-cycle count for port 1) is compared against the DUT
//               on every falling edge; directed sequences add literal checks.
// Revision    : 1.0  initial release
// ============================================================================
module tb_map_arbiter;

  localparam int MAXWAIT = 4;

  typedef struct {
    int id;
    int val;
    int due;
  } exp_t;

  logic clk;
  logic reset_n;

  int n_tests = 0;
  int n_fail  = 0;

  map_arbiter_if #(.COLBITS(4), .ROWBITS(4), .BITS(2)) bus ();

  map_arbiter #(
    .COLBITS(4), .ROWBITS(4), .BITS(2), .MAXWAIT(MAXWAIT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Map ROM model: value = col[1:0] | row[3:2]
  function automatic logic [1:0] rom_f(input logic [3:0] c, input logic [3:0] r);
    return c[1:0] | r[3:2];
  endfunction

  assign bus.rom_val = rom_f(bus.rom_col, bus.rom_row);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and per-cycle compare (falling edge)
  // ---------------------------------------------------------------------------
  exp_t pend[$];
  int   cyc     = 0;
  int   m_wait  = 0;
  int   m_col   = 0;
  int   m_row   = 0;
  int   m_val   = 0;
  int   e_r0, e_r1, g0, g1;

  always @(negedge clk) begin
    if (!reset_n) begin
      pend.delete();
      m_wait = 0; m_col = 0; m_row = 0; m_val = 0;
      chk("rst_ready0",   32'(bus.req0_ready),  0);
      chk("rst_ready1",   32'(bus.req1_ready),  0);
      chk("rst_rom_col",  32'(bus.rom_col),     0);
      chk("rst_rom_row",  32'(bus.rom_row),     0);
      chk("rst_resp0",    32'(bus.resp0_valid), 0);
      chk("rst_resp1",    32'(bus.resp1_valid), 0);
      chk("rst_resp_val", 32'(bus.resp_val),    0);
    end else begin
      e_r0 = 0;
      e_r1 = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        e_r0  = (pend[0].id == 0) ? 1 : 0;
        e_r1  = (pend[0].id == 1) ? 1 : 0;
        m_val = pend[0].val;
        void'(pend.pop_front());
      end
      chk("rom_col",  32'(bus.rom_col),     32'(m_col));
      chk("rom_row",  32'(bus.rom_row),     32'(m_row));
      chk("resp0",    32'(bus.resp0_valid), 32'(e_r0));
      chk("resp1",    32'(bus.resp1_valid), 32'(e_r1));
      chk("resp_val", 32'(bus.resp_val),    32'(m_val));

      // Who wins the upcoming edge
      g1 = (bus.req1_valid && (!bus.req0_valid || m_wait >= MAXWAIT)) ? 1 : 0;
      g0 = (bus.req0_valid && g1 == 0) ? 1 : 0;
      chk("ready0", 32'(bus.req0_ready), 32'(g0));
      chk("ready1", 32'(bus.req1_ready), 32'(g1));

      if (g1 == 1) begin
        m_col = int'(bus.req1_col);
        m_row = int'(bus.req1_row);
        pend.push_back('{1, int'(rom_f(bus.req1_col, bus.req1_row)), cyc + 2});
        m_wait = 0;
      end else begin
        if (g0 == 1) begin
          m_col = int'(bus.req0_col);
          m_row = int'(bus.req0_row);
          pend.push_back('{0, int'(rom_f(bus.req0_col, bus.req0_row)), cyc + 2});
        end
        if (bus.req1_valid && m_wait < 15) m_wait++;
      end
    end
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic set_in(input logic v0, input logic [3:0] c0, input logic [3:0] r0,
                        input logic v1, input logic [3:0] c1, input logic [3:0] r1);
    bus.req0_valid = v0; bus.req0_col = c0; bus.req0_row = r0;
    bus.req1_valid = v1; bus.req1_col = c1; bus.req1_row = r1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic a0, a1;

  initial begin
    reset_n = 1'b0;
    set_in(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single port-0 lookup, accepted on the first edge out of reset
    set_in(1'b1, 4'd3, 4'd5, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    chk("t35_ready0", 32'(bus.req0_ready), 1);
    chk("t35_ready1", 32'(bus.req1_ready), 0);
    step(); set_in(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    chk("t35_rom_col", 32'(bus.rom_col), 3);
    chk("t35_rom_row", 32'(bus.rom_row), 5);
    chk("t35_early",   32'(bus.resp0_valid), 0);
    step();
    @(negedge clk);
    chk("t35_resp0",    32'(bus.resp0_valid), 1);
    chk("t35_resp1",    32'(bus.resp1_valid), 0);
    chk("t35_resp_val", 32'(bus.resp_val), 3);
    step();
    @(negedge clk);
    chk("t35_pulse_end", 32'(bus.resp0_valid), 0);
    chk("t35_hold_val",  32'(bus.resp_val), 3);

    // Continuous contention: port 1 forced through every fifth cycle
    for (int i = 0; i < 10; i++) begin
      step(); set_in(1'b1, 4'(i), 4'd0, 1'b1, 4'd7, 4'd9);
      @(negedge clk);
      chk("t36_grant1", 32'(bus.req1_ready), (i == 4 || i == 9) ? 1 : 0);
      chk("t36_grant0", 32'(bus.req0_ready), (i == 4 || i == 9) ? 0 : 1);
    end
    step(); set_in(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    repeat (3) step();

    // Four back-to-back port-0 lookups, ROM value = col[1:0]
    for (int i = 0; i < 6; i++) begin
      step();
      if (i < 4) set_in(1'b1, 4'(i), 4'd0, 1'b0, 4'd0, 4'd0);
      else       set_in(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
      @(negedge clk);
      if (i >= 2) begin
        chk("t37_resp0",    32'(bus.resp0_valid), 1);
        chk("t37_resp_val", 32'(bus.resp_val), 32'(i - 2));
      end
    end
    repeat (2) step();

    // Alternating ports: 1, 0, 1, 0
    for (int i = 0; i < 6; i++) begin
      step();
      if (i < 4 && (i % 2) == 0) set_in(1'b0, 4'd0, 4'd0, 1'b1, 4'(i + 1), 4'd4);
      else if (i < 4)            set_in(1'b1, 4'(i + 1), 4'd8, 1'b0, 4'd0, 4'd0);
      else                       set_in(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
      @(negedge clk);
      if (i >= 2) begin
        chk("t38_resp1", 32'(bus.resp1_valid), ((i - 2) % 2 == 0) ? 1 : 0);
        chk("t38_resp0", 32'(bus.resp0_valid), ((i - 2) % 2 == 1) ? 1 : 0);
      end
    end
    repeat (2) step();

    // Reset one cycle after an acceptance discards the lookup
    step(); set_in(1'b1, 4'd6, 4'd2, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    chk("t39_ready0", 32'(bus.req0_ready), 1);
    step();
    reset_n = 1'b0;
    set_in(1'b1, 4'd1, 4'd1, 1'b1, 4'd2, 4'd2);
    @(negedge clk);
    chk("t39_rdy0_rst", 32'(bus.req0_ready), 0);
    chk("t39_rdy1_rst", 32'(bus.req1_ready), 0);
    chk("t39_col_rst",  32'(bus.rom_col), 0);
    step();
    reset_n = 1'b1;
    set_in(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t39_no_resp0", 32'(bus.resp0_valid), 0);
      chk("t39_no_resp1", 32'(bus.resp1_valid), 0);
      chk("t39_val_zero", 32'(bus.resp_val), 0);
      step();
    end
    set_in(1'b1, 4'd2, 4'd12, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    chk("t39_next_rdy", 32'(bus.req0_ready), 1);
    step(); set_in(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    step();
    @(negedge clk);
    chk("t39_next_resp", 32'(bus.resp0_valid), 1);
    chk("t39_next_val",  32'(bus.resp_val), 3);

    // Port 1 alone is granted every cycle; port 0 then wins contention
    step(); set_in(1'b0, 4'd0, 4'd0, 1'b1, 4'd5, 4'd5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t40_alone1", 32'(bus.req1_ready), 1);
      step();
    end
    set_in(1'b1, 4'd8, 4'd8, 1'b1, 4'd5, 4'd5);
    @(negedge clk);
    chk("t40_win0",  32'(bus.req0_ready), 1);
    chk("t40_lose1", 32'(bus.req1_ready), 0);
    step(); set_in(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    repeat (3) step();

    // Random traffic with occasional resets; denied requests hold address
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk);
      #1;
      if (!reset_n)                          reset_n = 1'b1;
      else if ($urandom_range(0, 249) == 0)  reset_n = 1'b0;
      if (!(bus.req0_valid && !a0)) begin
        bus.req0_valid = ($urandom_range(0, 99) < 60);
        bus.req0_col   = 4'($urandom);
        bus.req0_row   = 4'($urandom);
      end
      if (!(bus.req1_valid && !a1)) begin
        bus.req1_valid = ($urandom_range(0, 99) < 70);
        bus.req1_col   = 4'($urandom);
        bus.req1_row   = 4'($urandom);
      end
    end
    reset_n = 1'b1;
    set_in(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/map_arbiter.md
MAP_ARBITER -- requirements
Module: map_arbiter

Interface
REQ-001 Parameter COLBITS, default 4: map column address width.
REQ-002 Parameter ROWBITS, default 4: map row address width.
REQ-003 Parameter BITS, default 2: map cell value width.
REQ-004 Parameter MAXWAIT, default 4, legal range 1..15: cycles port 1 may be denied before it is forced a grant.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 req0_valid  input  1  port 0 (tracer) lookup request.
REQ-008 req0_col  input  COLBITS  port 0 column.
REQ-009 req0_row  input  ROWBITS  port 0 row.
REQ-010 req0_ready  output  1  port 0 request accepted this cycle.
REQ-011 req1_valid / req1_col / req1_row / req1_ready: same as REQ-007..010, port 1 (overlay/debug).
REQ-012 rom_col  output  COLBITS  registered column to map ROM.
REQ-013 rom_row  output  ROWBITS  registered row to map ROM.
REQ-014 rom_val  input  BITS  combinational map ROM value for rom_col/rom_row.
REQ-015 resp0_valid  output  1  one-cycle pulse: resp_val holds port 0 result.
REQ-016 resp1_valid  output  1  one-cycle pulse: resp_val holds port 1 result.
REQ-017 resp_val  output  BITS  registered lookup result, shared by both ports.

Function
REQ-018 Acceptance on a port SHALL occur exactly when reqN_valid and reqN_ready are both high at a rising edge.
REQ-019 reqN_ready SHALL be combinational from reqN_valid, the other port's valid and the wait counter; at most one ready high per cycle; ready never high while its valid is low.
REQ-020 Only port 0 valid -> grant 0; only port 1 valid -> grant 1; neither -> no grant.
REQ-021 Both valid: grant 0 unless wait1 >= MAXWAIT, then grant 1.
REQ-022 wait1 (4-bit) SHALL increment when req1_valid high and port 1 not granted, saturate at 15, clear to 0 on port 1 grant, and hold when req1_valid is low.
REQ-023 On acceptance, the accepted col/row SHALL be registered into rom_col/rom_row, and stage-1 valid/id registered (id 0 or 1); with no acceptance, rom_col/rom_row hold their previous value and stage-1 valid goes low.
REQ-024 Cycle after stage 1 valid: rom_val SHALL be captured into resp_val, and resp0_valid or resp1_valid per id pulses high for one cycle.
REQ-025 Latency: acceptance at edge N -> resp pulse visible after edge N+2; throughput one lookup per cycle, back-to-back from either port with no bubble.
REQ-026 Responses SHALL be returned in acceptance order; no response backpressure exists; requesters capture on the pulse.
REQ-027 resp_val SHALL hold its last value when no response pulse is active.
REQ-028 resp0_valid and resp1_valid SHALL never be high together.
REQ-029 Requester SHALL hold col/row stable while valid high and ready low; arbiter behaviour otherwise is unspecified.
REQ-030 All address bits SHALL pass unmodified; no wrap or clamp of col/row.

Reset
REQ-031 reset_n low SHALL immediately force rom_col=0, rom_row=0, resp_val=0, resp0_valid=0, resp1_valid=0, stage-1 valid=0, wait1=0.
REQ-032 reset_n low SHALL force req0_ready=0 and req1_ready=0 regardless of valids.
REQ-033 In-flight lookups at reset SHALL be discarded; no response pulse for them after reset_n rises.
REQ-034 First acceptance SHALL be possible at the first rising edge with reset_n high.

Verification
REQ-035 Port 0 only, col=3 row=5, ROM model returns 2'b11 -> req0_ready high in request cycle, rom_col=3 rom_row=5 after edge 1, resp0_valid pulse with resp_val=2'b11 after edge 2, resp1_valid stays 0.
REQ-036 Both ports valid continuously, MAXWAIT=4 -> grant pattern 0,0,0,0,1,0,0,0,0,1...; wait1 goes 1,2,3,4,0.
REQ-037 Port 0 issues 4 back-to-back lookups (0,0),(1,0),(2,0),(3,0), ROM value = col[1:0] -> four consecutive resp0_valid pulses with resp_val 0,1,2,3, no gaps.
REQ-038 Alternating ports each cycle (port 1 only, then port 0 only) -> resp1/resp0 pulses alternate in same order, 2-cycle latency each.
REQ-039 reset_n asserted one cycle after an acceptance -> all outputs 0 immediately; no response pulse after release; next request completes normally.
REQ-040 Port 1 held valid with port 0 idle, then port 0 asserted -> port 1 granted every cycle while alone, wait1 stays 0, port 0 wins next contended cycle.
